// File: rtl/i2s_sample_buffer_pkg.sv
// Shared definitions for the I2S sample buffer: register map, bit positions, FSM states.
package i2s_pkg;

   localparam logic [2:0] ADDR_CTRL    = 3'd0;
   localparam logic [2:0] ADDR_STATUS  = 3'd1;
   localparam logic [2:0] ADDR_CLK_DIV = 3'd2;
   localparam logic [2:0] ADDR_LEFT    = 3'd3;
   localparam logic [2:0] ADDR_RIGHT   = 3'd4;

   localparam int CTRL_EN    = 0;
   localparam int CTRL_FLUSH = 1;
   localparam int CTRL_IE    = 2;

   localparam int STAT_EMPTY     = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_UNDERRUN  = 2;
   localparam int STAT_OVERFLOW  = 3;
   localparam int STAT_LEVEL_LSB = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PRIME = 2'd1,
      S_RUN   = 2'd2
   } state_e;

endpackage

// File: rtl/i2s_sample_buffer_fifo.sv
// Synchronous stereo-frame FIFO; push on full and pop on empty are ignored, flush empties it.
module sample_fifo #(
   parameter int W          = 32,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                flush,
   input  logic                push,
   input  logic [W-1:0]        din,
   input  logic                pop,
   output logic [W-1:0]        dout,
   output logic                full,
   output logic                empty,
   output logic [DEPTH_LOG2:0] level
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [W-1:0]            mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]     level_q, level_d;
   logic                    do_push, do_pop;

   assign full  = (level_q == (DEPTH_LOG2+1)'(DEPTH));
   assign empty = (level_q == '0);
   assign level = level_q;
   assign dout  = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push & ~full & ~flush;
      do_pop   = pop & ~empty & ~flush;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         // Pointer widths make the wrap modulo depth implicit.
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         level_d = level_q + {{DEPTH_LOG2{1'b0}}, do_push} - {{DEPTH_LOG2{1'b0}}, do_pop};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/i2s_sample_buffer.sv
// Avalon-MM front end for the I2S serializer: register file, frame FIFO, prefill FSM
// and an output register handing stereo frames to the core via valid/ready.
module i2s_sample_buffer
   import i2s_pkg::*;
#(
   parameter int DW         = 16,
   parameter int DEPTH_LOG2 = 4,
   parameter int PREFILL    = 4,
   parameter int DIV_W      = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       avs_address,
   input  logic             avs_write,
   input  logic [31:0]      avs_writedata,
   input  logic             avs_read,
   output logic [31:0]      avs_readdata,
   output logic             irq,
   output logic [DIV_W-1:0] clk_div,
   output logic [DW-1:0]    smp_left,
   output logic [DW-1:0]    smp_right,
   output logic             smp_valid,
   input  logic             smp_ready
);

   localparam int             LW         = DEPTH_LOG2 + 1;
   localparam logic [LW-1:0]  PREFILL_LV = LW'(PREFILL);

   logic              en_q, en_d, ie_q, ie_d;
   logic [DIV_W-1:0]  clk_div_q, clk_div_d;
   logic [DW-1:0]     left_q, left_d;
   logic              und_q, und_d, ovf_q, ovf_d;
   logic [31:0]       rdata_q, rdata_d;
   state_e            state_q, state_d;
   logic              ovld_q, ovld_d;
   logic [2*DW-1:0]   odata_q, odata_d;

   logic              wr_ctrl, wr_status, flush, push_req, pop, und_set;
   logic [2*DW-1:0]   fifo_dout;
   logic              fifo_full, fifo_empty;
   logic [LW-1:0]     fifo_level;
   logic [31:0]       status;

   assign wr_ctrl   = avs_write && (avs_address == ADDR_CTRL);
   assign wr_status = avs_write && (avs_address == ADDR_STATUS);
   assign push_req  = avs_write && (avs_address == ADDR_RIGHT);
   assign flush     = wr_ctrl && avs_writedata[CTRL_FLUSH];

   sample_fifo #(.W(2*DW), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .push    (push_req),
      .din     ({left_q, avs_writedata[DW-1:0]}),
      .pop     (pop),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   always_comb begin
      status                        = '0;
      status[STAT_EMPTY]            = fifo_empty;
      status[STAT_FULL]             = fifo_full;
      status[STAT_UNDERRUN]         = und_q;
      status[STAT_OVERFLOW]         = ovf_q;
      status[STAT_LEVEL_LSB +: 8]   = 8'(fifo_level);
   end

   // Register file and read mux.
   always_comb begin
      en_d      = en_q;
      ie_d      = ie_q;
      clk_div_d = clk_div_q;
      left_d    = left_q;
      rdata_d   = rdata_q;
      if (wr_ctrl) begin
         en_d = avs_writedata[CTRL_EN];
         ie_d = avs_writedata[CTRL_IE];
      end
      if (avs_write && avs_address == ADDR_CLK_DIV) clk_div_d = avs_writedata[DIV_W-1:0];
      if (avs_write && avs_address == ADDR_LEFT)    left_d    = avs_writedata[DW-1:0];
      if (avs_read) begin
         case (avs_address)
            ADDR_CTRL:    rdata_d = {29'd0, ie_q, 1'b0, en_q};
            ADDR_STATUS:  rdata_d = status;
            ADDR_CLK_DIV: rdata_d = 32'(clk_div_q);
            default:      rdata_d = '0;
         endcase
      end
   end

   // Streaming FSM and output register; the EN/FLUSH overrides come last so they win.
   always_comb begin
      state_d = state_q;
      ovld_d  = ovld_q;
      odata_d = odata_q;
      pop     = 1'b0;
      und_set = 1'b0;
      case (state_q)
         S_IDLE: begin
            ovld_d = 1'b0;
            if (en_d) state_d = S_PRIME;
         end
         S_PRIME: begin
            if (fifo_level >= PREFILL_LV || fifo_full) begin
               state_d = S_RUN;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  ovld_d  = 1'b1;
                  odata_d = fifo_dout;
               end
            end
         end
         S_RUN: begin
            if (smp_ready && !ovld_q) und_set = 1'b1;
            if (!ovld_q || smp_ready) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  ovld_d  = 1'b1;
                  odata_d = fifo_dout;
               end else begin
                  ovld_d = 1'b0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (!en_d) begin
         state_d = S_IDLE;
         ovld_d  = 1'b0;
         pop     = 1'b0;
      end
      if (flush) begin
         state_d = en_d ? S_PRIME : S_IDLE;
         ovld_d  = 1'b0;
         pop     = 1'b0;
      end
   end

   // Sticky flags: a new event in the same cycle as its W1C keeps the flag set.
   always_comb begin
      und_d = (und_q & ~(wr_status & avs_writedata[STAT_UNDERRUN])) | und_set;
      ovf_d = (ovf_q & ~(wr_status & avs_writedata[STAT_OVERFLOW])) | (push_req & fifo_full);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         en_q      <= 1'b0;
         ie_q      <= 1'b0;
         clk_div_q <= '0;
         left_q    <= '0;
         und_q     <= 1'b0;
         ovf_q     <= 1'b0;
         rdata_q   <= '0;
         state_q   <= S_IDLE;
         ovld_q    <= 1'b0;
         odata_q   <= '0;
      end else begin
         en_q      <= en_d;
         ie_q      <= ie_d;
         clk_div_q <= clk_div_d;
         left_q    <= left_d;
         und_q     <= und_d;
         ovf_q     <= ovf_d;
         rdata_q   <= rdata_d;
         state_q   <= state_d;
         ovld_q    <= ovld_d;
         odata_q   <= odata_d;
      end
   end

   assign avs_readdata = rdata_q;
   assign irq          = ie_q & (und_q | ovf_q);
   assign clk_div      = clk_div_q;
   assign smp_valid    = ovld_q;
   assign smp_left     = odata_q[2*DW-1:DW];
   assign smp_right    = odata_q[DW-1:0];

endmodule

// File: tb/tb_i2s_sample_buffer.sv
// Scoreboard bench: accepted frames queue up in push order; a monitor checks every presented frame.
module tb_i2s_sample_buffer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  avs_address;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic        avs_read;
   logic [31:0] avs_readdata;
   logic        irq;
   logic [7:0]  clk_div;
   logic [15:0] smp_left, smp_right;
   logic        smp_valid;
   logic        smp_ready;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] frm[4];
   logic [31:0] rd_v;

   i2s_sample_buffer #(.DW(16), .DEPTH_LOG2(4), .PREFILL(4), .DIV_W(8)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .avs_address   (avs_address),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .avs_read      (avs_read),
      .avs_readdata  (avs_readdata),
      .irq           (irq),
      .clk_div       (clk_div),
      .smp_left      (smp_left),
      .smp_right     (smp_right),
      .smp_valid     (smp_valid),
      .smp_ready     (smp_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, got, want);
      end
   endtask

   // Tasks start and end at posedge+1.
   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      avs_address = a; avs_writedata = d; avs_write = 1'b1;
      @(posedge clk); #1;
      avs_write = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      avs_address = a; avs_read = 1'b1;
      @(posedge clk); #1;
      avs_read = 1'b0;
      d = avs_readdata;
   endtask

   task automatic push(input logic [31:0] f);
      wr(3'd3, {16'd0, f[31:16]});
      wr(3'd4, {16'd0, f[15:0]});
      exp_q.push_back(f);
   endtask

   task automatic pulse();
      smp_ready = 1'b1;
      @(posedge clk); #1;
      smp_ready = 1'b0;
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 2 && !smp_valid; i++) idle(1);
   endtask

   // Monitor: any presented frame must be the oldest outstanding accepted frame.
   always @(negedge clk) begin
      if (reset_n && smp_valid) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_frame got=%h want=none", {smp_left, smp_right});
         end else begin
            chk("frame_order", {smp_left, smp_right}, exp_q[0]);
            if (smp_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      reset_n = 1'b0; avs_address = '0; avs_write = 1'b0; avs_writedata = '0;
      avs_read = 1'b0; smp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      idle(1);
      chk("rst_outputs", {avs_readdata[15:0], 7'd0, irq, clk_div, 7'd0, smp_valid}, 32'd0);
      chk("rst_samples", {smp_left, smp_right}, 32'd0);
      rd(3'd1, rd_v); chk("rst_status", rd_v, 32'h1);

      wr(3'd2, 32'hFFFF_FF5A);
      rd(3'd2, rd_v); chk("clkdiv_read", rd_v, 32'h5A);
      chk("clkdiv_out", {24'd0, clk_div}, 32'h5A);
      rd(3'd5, rd_v); chk("addr5_read", rd_v, 32'h0);

      // Prefill: nothing streams until the 4th frame.
      wr(3'd0, 32'h1);
      for (int i = 0; i < 4; i++) frm[i] = $urandom;
      for (int i = 0; i < 3; i++) push(frm[i]);
      idle(3);
      chk("prefill_hold", {31'd0, smp_valid}, 32'd0);
      push(frm[3]);
      wait_valid();
      chk("prefill_start", {31'd0, smp_valid}, 32'd1);
      chk("first_frame", {smp_left, smp_right}, frm[0]);

      // Backpressure: frame stays put, then one pulse advances exactly one frame.
      idle(20);
      chk("hold_stable", {smp_left, smp_right}, frm[0]);
      pulse();
      chk("next_valid", {31'd0, smp_valid}, 32'd1);
      chk("next_frame", {smp_left, smp_right}, frm[1]);

      // Drain, then one more ready pulse flags an underrun.
      for (int i = 0; i < 20 && smp_valid; i++) pulse();
      chk("drained", {31'd0, smp_valid}, 32'd0);
      rd(3'd1, rd_v); chk("no_underrun_yet", rd_v, 32'h1);
      pulse();
      rd(3'd1, rd_v); chk("underrun_set", rd_v, 32'h5);
      chk("irq_masked", {31'd0, irq}, 32'd0);
      push($urandom);
      wait_valid();
      chk("resume_after_underrun", {31'd0, smp_valid}, 32'd1);
      pulse();
      wr(3'd1, 32'h4);
      rd(3'd1, rd_v); chk("underrun_w1c", rd_v, 32'h1);

      // Random streaming with random ready.
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               push($urandom);
               idle($urandom_range(0, 3));
            end
         end
         begin
            for (int c = 0; c < 80; c++) begin
               smp_ready = ($urandom_range(0, 2) == 0);
               @(posedge clk); #1;
            end
            smp_ready = 1'b0;
         end
      join
      for (int i = 0; i < 40 && (smp_valid || exp_q.size() > 0); i++) pulse();
      chk("random_all_delivered", exp_q.size(), 32'd0);
      wr(3'd1, 32'hC);

      // Flush mid-stream with 8 frames in the FIFO (a 9th sits in the output register).
      for (int i = 0; i < 9; i++) push($urandom);
      idle(1);
      rd(3'd1, rd_v); chk("level8", rd_v, 32'h0800);
      wr(3'd0, 32'h3);
      exp_q.delete();
      chk("flush_valid", {31'd0, smp_valid}, 32'd0);
      rd(3'd1, rd_v); chk("flush_status", rd_v, 32'h1);
      rd(3'd2, rd_v); chk("flush_clkdiv", rd_v, 32'h5A);
      rd(3'd0, rd_v); chk("ctrl_read", rd_v, 32'h1);
      for (int i = 0; i < 3; i++) push($urandom);
      idle(3);
      chk("reprime_hold", {31'd0, smp_valid}, 32'd0);
      push($urandom);
      wait_valid();
      chk("reprime_start", {31'd0, smp_valid}, 32'd1);
      wr(3'd0, 32'h3);
      exp_q.delete();

      // Overflow with streaming disabled.
      wr(3'd0, 32'h0);
      for (int i = 0; i < 16; i++) push($urandom);
      rd(3'd1, rd_v); chk("full_status", rd_v, 32'h1002);
      wr(3'd0, 32'h4);
      chk("irq_idle", {31'd0, irq}, 32'd0);
      push($urandom);
      rd(3'd1, rd_v); chk("overflow_status", rd_v, 32'h100A);
      chk("irq_overflow", {31'd0, irq}, 32'd1);
      chk("en_off_valid", {31'd0, smp_valid}, 32'd0);
      wr(3'd1, 32'h8);
      rd(3'd1, rd_v); chk("overflow_w1c", rd_v, 32'h1002);
      chk("irq_cleared", {31'd0, irq}, 32'd0);
      wr(3'd0, 32'h2);
      exp_q.delete();
      rd(3'd1, rd_v); chk("final_empty", rd_v, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
